// File: rtl/fft4_pass_scheduler_if.sv
// Handshake bundle between the radix-4 pass scheduler, the data-memory banks and the
// butterfly/twiddle datapath. The master side is the scheduler.
interface fft4_pass_scheduler_if #(
    parameter int ADDR_W  = 13,
    parameter int LABLE_W = 11,
    parameter int PASS_W  = 3
);
    logic               start;
    logic               hold;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr0;
    logic [ADDR_W-1:0]  rd_addr1;
    logic [ADDR_W-1:0]  rd_addr2;
    logic [ADDR_W-1:0]  rd_addr3;
    logic               dp_valid;
    logic [LABLE_W-1:0] dp_lable;
    logic               dp_ready;
    logic [LABLE_W-1:0] dp_index;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr0;
    logic [ADDR_W-1:0]  wr_addr1;
    logic [ADDR_W-1:0]  wr_addr2;
    logic [ADDR_W-1:0]  wr_addr3;
    logic [PASS_W-1:0]  pass_idx;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        input  start, hold, dp_ready, dp_index,
        output rd_en, rd_addr0, rd_addr1, rd_addr2, rd_addr3,
               dp_valid, dp_lable,
               wr_en, wr_addr0, wr_addr1, wr_addr2, wr_addr3,
               pass_idx, busy, done, err
    );

    modport slave (
        output start, hold, dp_ready, dp_index,
        input  rd_en, rd_addr0, rd_addr1, rd_addr2, rd_addr3,
               dp_valid, dp_lable,
               wr_en, wr_addr0, wr_addr1, wr_addr2, wr_addr3,
               pass_idx, busy, done, err
    );
endinterface

// File: rtl/fft4_pass_scheduler.sv
// Pass sequencer for an in-place radix-4 FFT: issues one 4-point group per cycle,
// tracks results in flight and maps echoed labels back to write-back addresses.
module fft4_pass_scheduler #(
    parameter int ADDR_W     = 13,
    parameter int LABLE_W    = 11,
    parameter int NUM_PASSES = 6,
    parameter int PASS_W     = 3,
    parameter int RD_LAT     = 1,
    parameter int SPAN_DIR   = 0
) (
    input  logic clk,
    input  logic rst_n,
    fft4_pass_scheduler_if.master bus
);
    localparam int GROUPS = 1 << LABLE_W;
    localparam int CNT_W  = LABLE_W + 1;
    localparam int SH_W   = PASS_W + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_NEXT,
        S_DONE
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   issue_cnt_reg;
    logic [CNT_W-1:0]   wb_cnt_reg;
    logic [CNT_W-1:0]   outstanding;
    logic [PASS_W-1:0]  pass_reg;
    logic [PASS_W-1:0]  span_reg;
    logic               rd_en_reg;
    logic [LABLE_W-1:0] rd_lable_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               err_reg;
    logic               wr_en_reg;
    logic [ADDR_W-1:0]  rd_addr_reg  [4];
    logic [ADDR_W-1:0]  rd_addr_next [4];
    logic [ADDR_W-1:0]  wr_addr_reg  [4];
    logic [ADDR_W-1:0]  wr_addr_next [4];
    logic               run_start;
    logic               err_hit;
    logic               vld_pipe [RD_LAT];
    logic [LABLE_W-1:0] lab_pipe [RD_LAT];

    // addr_k = blk*4^(p+1) + off + k*4^p, built from shifts and masks only.
    function automatic logic [ADDR_W-1:0] grp_addr(
        input logic [LABLE_W-1:0] g,
        input logic [PASS_W-1:0]  p,
        input logic [1:0]         k
    );
        logic [SH_W-1:0]   sh_lo;
        logic [SH_W-1:0]   sh_hi;
        logic [ADDR_W-1:0] gw;
        logic [ADDR_W-1:0] mask;
        sh_lo = {1'b0, p, 1'b0};
        sh_hi = sh_lo + SH_W'(2);
        gw    = ADDR_W'(g);
        mask  = (ADDR_W'(1) << sh_lo) - ADDR_W'(1);
        return ((gw >> sh_lo) << sh_hi) | (gw & mask) | (ADDR_W'(k) << sh_lo);
    endfunction

    function automatic logic [PASS_W-1:0] span_of(input logic [PASS_W-1:0] pidx);
        if (SPAN_DIR != 0) begin
            return PASS_W'(NUM_PASSES - 1) - pidx;
        end
        return pidx;
    endfunction

    assign outstanding = issue_cnt_reg - wb_cnt_reg;
    assign run_start   = (state_reg == S_IDLE) && bus.start;
    // Results must come back in issue order, so the expected label is the write-back count.
    assign err_hit     = bus.dp_ready &&
                         ((state_reg == S_IDLE) || (outstanding == '0) ||
                          (bus.dp_index != wb_cnt_reg[LABLE_W-1:0]));

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_addr
            assign rd_addr_next[gi] = grp_addr(issue_cnt_reg[LABLE_W-1:0], span_reg, 2'(gi));
            assign wr_addr_next[gi] = grp_addr(bus.dp_index, span_reg, 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            issue_cnt_reg <= '0;
            wb_cnt_reg    <= '0;
            pass_reg      <= '0;
            span_reg      <= '0;
            rd_en_reg     <= 1'b0;
            rd_lable_reg  <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                rd_addr_reg[k] <= '0;
            end
        end else begin
            rd_en_reg <= 1'b0;
            done_reg  <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        state_reg     <= S_ISSUE;
                        pass_reg      <= '0;
                        span_reg      <= span_of('0);
                        issue_cnt_reg <= '0;
                        busy_reg      <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (!bus.hold) begin
                        rd_en_reg     <= 1'b1;
                        rd_lable_reg  <= issue_cnt_reg[LABLE_W-1:0];
                        for (int k = 0; k < 4; k++) begin
                            rd_addr_reg[k] <= rd_addr_next[k];
                        end
                        issue_cnt_reg <= issue_cnt_reg + CNT_W'(1);
                        if (issue_cnt_reg == CNT_W'(GROUPS - 1)) begin
                            state_reg <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (wb_cnt_reg == CNT_W'(GROUPS)) begin
                        if (pass_reg == PASS_W'(NUM_PASSES - 1)) begin
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    // Entered only after the last write of the pass, so the next pass never
                    // reads data that is still being written back.
                    pass_reg      <= pass_reg + PASS_W'(1);
                    span_reg      <= span_of(pass_reg + PASS_W'(1));
                    issue_cnt_reg <= '0;
                    state_reg     <= S_ISSUE;
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase

            if (run_start || (state_reg == S_NEXT)) begin
                wb_cnt_reg <= '0;
            end else if (bus.dp_ready && (state_reg != S_IDLE) && (outstanding != '0)) begin
                wb_cnt_reg <= wb_cnt_reg + CNT_W'(1);
            end

            err_reg <= err_hit || (err_reg && !run_start);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe[0] <= 1'b0;
            lab_pipe[0] <= '0;
        end else begin
            vld_pipe[0] <= rd_en_reg;
            lab_pipe[0] <= rd_lable_reg;
        end
    end

    generate
        for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_lat
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_pipe[gi] <= 1'b0;
                    lab_pipe[gi] <= '0;
                end else begin
                    vld_pipe[gi] <= vld_pipe[gi-1];
                    lab_pipe[gi] <= lab_pipe[gi-1];
                end
            end
        end
    endgenerate

    // Write-back is performed even when the result is flagged as a protocol error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_reg <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                wr_addr_reg[k] <= '0;
            end
        end else begin
            wr_en_reg <= bus.dp_ready;
            if (bus.dp_ready) begin
                for (int k = 0; k < 4; k++) begin
                    wr_addr_reg[k] <= wr_addr_next[k];
                end
            end
        end
    end

    assign bus.rd_en    = rd_en_reg;
    assign bus.rd_addr0 = rd_addr_reg[0];
    assign bus.rd_addr1 = rd_addr_reg[1];
    assign bus.rd_addr2 = rd_addr_reg[2];
    assign bus.rd_addr3 = rd_addr_reg[3];
    assign bus.dp_valid = vld_pipe[RD_LAT-1];
    assign bus.dp_lable = lab_pipe[RD_LAT-1];
    assign bus.wr_en    = wr_en_reg;
    assign bus.wr_addr0 = wr_addr_reg[0];
    assign bus.wr_addr1 = wr_addr_reg[1];
    assign bus.wr_addr2 = wr_addr_reg[2];
    assign bus.wr_addr3 = wr_addr_reg[3];
    assign bus.pass_idx = pass_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.err      = err_reg;
endmodule

// File: tb/tb_fft4_pass_scheduler.sv
// Directed bench for fft4_pass_scheduler: full runs with an echoing datapath model,
// issue stall, protocol-error injection and mid-run reset.
module tb_fft4_pass_scheduler;
    localparam int ADDR_W     = 13;
    localparam int LABLE_W    = 11;
    localparam int NUM_PASSES = 6;
    localparam int PASS_W     = 3;
    localparam int GROUPS     = 2048;
    localparam int TOTAL      = NUM_PASSES * GROUPS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft4_pass_scheduler_if #(.ADDR_W(ADDR_W), .LABLE_W(LABLE_W), .PASS_W(PASS_W)) bus();

    fft4_pass_scheduler #(
        .ADDR_W(ADDR_W), .LABLE_W(LABLE_W), .NUM_PASSES(NUM_PASSES),
        .PASS_W(PASS_W), .RD_LAT(1), .SPAN_DIR(0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("check %s got=%0d ok", tag, got);
        end
    endtask

    // Datapath model: echoes each label four cycles after dp_valid; injection path for errors.
    logic               model_en;
    logic               model_ready;
    logic [LABLE_W-1:0] model_index;
    logic               inj_ready;
    logic [LABLE_W-1:0] inj_index;
    logic               echo_v [4];
    logic [LABLE_W-1:0] echo_l [4];

    assign bus.dp_ready = model_en ? model_ready : inj_ready;
    assign bus.dp_index = model_en ? model_index : inj_index;

    initial begin
        for (int i = 0; i < 4; i++) begin
            echo_v[i] = 1'b0;
            echo_l[i] = '0;
        end
        model_ready = 1'b0;
        model_index = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                for (int i = 0; i < 4; i++) begin
                    echo_v[i] = 1'b0;
                    echo_l[i] = '0;
                end
            end else begin
                for (int i = 3; i > 0; i--) begin
                    echo_v[i] = echo_v[i-1];
                    echo_l[i] = echo_l[i-1];
                end
                echo_v[0] = bus.dp_valid;
                echo_l[0] = bus.dp_lable;
            end
            model_ready = echo_v[3];
            model_index = echo_l[3];
        end
    end

    // Monitor: counts transactions per run and captures addresses of selected groups.
    int rd_total, wr_total, done_cnt, order_bad, hold_bad, lbl_bad;
    int rd_in_pass, wr_in_pass, cur_pass, lbl_exp;
    logic hold_prev;
    logic [ADDR_W-1:0] cap_rd [4][4];
    logic [ADDR_W-1:0] cap_wr [4];
    logic [ADDR_W-1:0] cap_hold;

    task automatic grab_rd(input int v);
        cap_rd[v][0] = bus.rd_addr0;
        cap_rd[v][1] = bus.rd_addr1;
        cap_rd[v][2] = bus.rd_addr2;
        cap_rd[v][3] = bus.rd_addr3;
    endtask

    initial begin
        rd_total = 0; wr_total = 0; done_cnt = 0; order_bad = 0; hold_bad = 0; lbl_bad = 0;
        rd_in_pass = 0; wr_in_pass = 0; cur_pass = 0; lbl_exp = 0; hold_prev = 1'b0;
        cap_hold = '0;
        for (int v = 0; v < 4; v++) begin
            cap_wr[v] = '0;
            for (int k = 0; k < 4; k++) cap_rd[v][k] = '0;
        end
        forever begin
            @(negedge clk);
            if (bus.start && !bus.busy) begin
                rd_total = 0; wr_total = 0; done_cnt = 0; order_bad = 0; hold_bad = 0;
                lbl_bad = 0; rd_in_pass = 0; wr_in_pass = 0; cur_pass = 0; lbl_exp = 0;
            end
            if (int'(bus.pass_idx) != cur_pass) begin
                cur_pass = int'(bus.pass_idx);
                rd_in_pass = 0;
                wr_in_pass = 0;
            end
            if (bus.rd_en) begin
                if (wr_total < GROUPS * cur_pass) order_bad++;
                if (hold_prev) hold_bad++;
                if (cur_pass == 0 && rd_in_pass == 5)    grab_rd(0);
                if (cur_pass == 0 && rd_in_pass == 2047) grab_rd(1);
                if (cur_pass == 1 && rd_in_pass == 5)    grab_rd(2);
                if (cur_pass == 5 && rd_in_pass == 5)    grab_rd(3);
                if (cur_pass == 0 && rd_in_pass == 100)  cap_hold = bus.rd_addr0;
                rd_in_pass++;
                rd_total++;
            end
            if (bus.dp_valid) begin
                if (int'(bus.dp_lable) != lbl_exp) lbl_bad++;
                lbl_exp = (lbl_exp + 1) % GROUPS;
            end
            if (bus.wr_en) begin
                if (cur_pass == 1 && wr_in_pass == 5) begin
                    cap_wr[0] = bus.wr_addr0;
                    cap_wr[1] = bus.wr_addr1;
                    cap_wr[2] = bus.wr_addr2;
                    cap_wr[3] = bus.wr_addr3;
                end
                wr_in_pass++;
                wr_total++;
            end
            if (bus.done) done_cnt++;
            hold_prev = bus.hold;
        end
    end

    // Hand-computed address vectors: p0 g5, p0 g2047, p1 g5, p5 g5.
    int exp_rd [4][4] = '{'{20, 21, 22, 23}, '{8188, 8189, 8190, 8191},
                          '{17, 21, 25, 29}, '{5, 1029, 2053, 3077}};
    int exp_wr [4] = '{17, 21, 25, 29};

    task automatic pulse_start();
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 30000; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_en"},    32'(bus.rd_en),    0);
        chk({tag, "_dp_valid"}, 32'(bus.dp_valid), 0);
        chk({tag, "_wr_en"},    32'(bus.wr_en),    0);
        chk({tag, "_busy"},     32'(bus.busy),     0);
        chk({tag, "_done"},     32'(bus.done),     0);
        chk({tag, "_err"},      32'(bus.err),      0);
        chk({tag, "_pass"},     32'(bus.pass_idx), 0);
        chk({tag, "_rd_addr0"}, 32'(bus.rd_addr0), 0);
        chk({tag, "_wr_addr3"}, 32'(bus.wr_addr3), 0);
        chk({tag, "_lable"},    32'(bus.dp_lable), 0);
    endtask

    initial begin
        bit seen;
        bit synced;
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        model_en  = 1'b1;
        inj_ready = 1'b0;
        inj_index = '0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // Run 1: full run with a 10-cycle stall once groups 0..99 are issued.
        pulse_start();
        chk("busy_after_start", 32'(bus.busy), 1);
        synced = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (rd_total == 99 && bus.rd_en) begin
                synced = 1'b1;
                break;
            end
        end
        chk("hold_sync", 32'(synced), 1);
        bus.hold = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("hold_frozen", 32'(rd_total), 100);
        bus.hold = 1'b0;
        wait_done(seen);
        chk("run1_done_seen", 32'(seen), 1);
        chk("run1_busy_at_done", 32'(bus.busy), 1);
        @(posedge clk); #1;
        chk("run1_done_fall", 32'(bus.done), 0);
        chk("run1_busy_fall", 32'(bus.busy), 0);
        chk("run1_pass_hold", 32'(bus.pass_idx), 5);
        chk("run1_rd_total", 32'(rd_total), TOTAL);
        chk("run1_wr_total", 32'(wr_total), TOTAL);
        chk("run1_done_cnt", 32'(done_cnt), 1);
        chk("run1_order", 32'(order_bad), 0);
        chk("run1_hold_rd", 32'(hold_bad), 0);
        chk("run1_lable_seq", 32'(lbl_bad), 0);
        chk("run1_err", 32'(bus.err), 0);
        chk("hold_resume_addr", 32'(cap_hold), 400);
        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("rd_addr_v%0d_k%0d", v, k), 32'(cap_rd[v][k]), 32'(exp_rd[v][k]));
            end
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("wr_addr_p1g5_k%0d", k), 32'(cap_wr[k]), 32'(exp_wr[k]));
        end

        // dp_ready while idle sets a sticky error.
        model_en = 1'b0;
        inj_ready = 1'b1;
        inj_index = '0;
        @(posedge clk); #1;
        inj_ready = 1'b0;
        chk("idle_ready_err", 32'(bus.err), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_err_sticky", 32'(bus.err), 1);

        // A new start clears it; then an out-of-order label 7 -> 9 sets it again.
        pulse_start();
        chk("start_clears_err", 32'(bus.err), 0);
        repeat (20) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            inj_ready = 1'b1;
            inj_index = LABLE_W'(i);
            @(posedge clk); #1;
        end
        inj_ready = 1'b0;
        chk("seq_labels_err", 32'(bus.err), 0);
        inj_ready = 1'b1;
        inj_index = LABLE_W'(9);
        @(posedge clk); #1;
        inj_ready = 1'b0;
        chk("skip_label_err", 32'(bus.err), 1);
        chk("skip_write_en", 32'(bus.wr_en), 1);
        chk("skip_write_addr", 32'(bus.wr_addr0), 36);
        repeat (5) @(posedge clk);
        #1;
        chk("skip_err_sticky", 32'(bus.err), 1);
        chk("skip_still_busy", 32'(bus.busy), 1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_clears_err", 32'(bus.err), 0);
        rst_n = 1'b1;
        model_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Run 3: abandoned by reset in the middle of pass 2.
        pulse_start();
        synced = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk); #1;
            if (bus.pass_idx == PASS_W'(2) && rd_total >= 2 * GROUPS + 300) begin
                synced = 1'b1;
                break;
            end
        end
        chk("reach_pass2", 32'(synced), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_done", 32'(done_cnt), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Run 4: clean run after the abandoned one.
        pulse_start();
        chk("run4_pass_start", 32'(bus.pass_idx), 0);
        wait_done(seen);
        chk("run4_done_seen", 32'(seen), 1);
        @(posedge clk); #1;
        chk("run4_rd_total", 32'(rd_total), TOTAL);
        chk("run4_wr_total", 32'(wr_total), TOTAL);
        chk("run4_done_cnt", 32'(done_cnt), 1);
        chk("run4_order", 32'(order_bad), 0);
        chk("run4_lable_seq", 32'(lbl_bad), 0);
        chk("run4_err", 32'(bus.err), 0);
        chk("run4_busy", 32'(bus.busy), 0);
        chk("run4_p0g5_k0", 32'(cap_rd[0][0]), 20);
        chk("run4_p0g5_k3", 32'(cap_rd[0][3]), 23);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
